// File: rtl/decoder_kind_seq_pkg.sv
// Shared types for the fetch-group decoder: instruction kinds, opcode field width, FSM states.
package p_instruction;

  localparam int OPC_W = 4;

  typedef enum logic [2:0] {
    K_RRR     = 3'd0,
    K_MEMORY  = 3'd1,
    K_MODEL   = 3'd2,
    K_RRI     = 3'd3,
    K_CUSTOM  = 3'd4,
    K_INVALID = 3'd5
  } e_kind;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } e_state;

endpackage

// File: rtl/decoder_kind_seq_if.sv
// Bus bundle between a fetch-group producer (master) and the decoder sequencer (slave).
interface decoder_kind_seq_if
  import p_instruction::*;
#(
  parameter int LANES   = 4,
  parameter int INSTR_W = 32
) ();
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  // Both sides: a beat transfers on a cycle where valid and ready are both high;
  // valid never waits on ready, and a presented beat holds stable until it transfers.
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*INSTR_W-1:0] in_group;
  logic [LANES-1:0]         in_lane_mask;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [INSTR_W-1:0]       out_instr;
  e_kind                    out_kind;
  logic [LW-1:0]            out_lane;
  logic                     out_last;
  logic                     out_trap;

  modport master (
    output in_valid, in_group, in_lane_mask, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_kind, out_lane, out_last, out_trap
  );

  modport slave (
    input  in_valid, in_group, in_lane_mask, flush, out_ready,
    output in_ready, out_valid, out_instr, out_kind, out_lane, out_last, out_trap
  );

endinterface

// File: rtl/decoder_kind_seq_classify.sv
// Combinational opcode classifier: top OPC_W bits of an instruction to its kind.
module m_kind_classify
  import p_instruction::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  output e_kind              o_kind
);

  logic [OPC_W-1:0] w_opc;
  logic             w_unused;

  assign w_opc    = i_instr[INSTR_W-1 -: OPC_W];
  assign w_unused = ^i_instr[INSTR_W-OPC_W-1:0];

  always_comb begin
    o_kind = K_INVALID;
    casez (w_opc)
      4'b0000: o_kind = K_RRR;
      4'b0001: o_kind = K_MEMORY;
      4'b0010: o_kind = K_MODEL;
      4'b01??: o_kind = K_RRI;
      4'b11??: o_kind = K_CUSTOM;
      default: o_kind = K_INVALID;
    endcase
  end

endmodule

// File: rtl/decoder_kind_seq.sv
// Holds one fetch group and emits its present lanes in order, one per cycle, with kind tags.
// Optional DECODER_KIND_TRAP_EN: an INVALID instruction ends the group and raises out_trap.
module decoder_kind_seq
  import p_instruction::*;
#(
  parameter int LANES   = 4,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  decoder_kind_seq_if.slave bus,
  output e_state            o_dbg_state
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  e_state                   r_state, w_state_nxt;
  logic [LANES*INSTR_W-1:0] r_group, w_group_nxt;
  logic [LANES-1:0]         r_mask, w_mask_nxt;
  logic [LANES-1:0]         w_sel_oh;
  logic [LW-1:0]            w_sel;
  logic [INSTR_W-1:0]       w_instr;
  e_kind                    w_kind;
  logic                     w_valid;
  logic                     w_trap;
  logic                     w_last;
  logic                     w_in_rdy;
  logic                     w_in_xfer;
  logic                     w_out_xfer;

  // Isolate the lowest remaining lane so masked lanes cost no cycles.
  assign w_sel_oh = r_mask & (~r_mask + LANES'(1));

  always_comb begin
    w_sel   = '0;
    w_instr = r_group[INSTR_W-1:0];
    for (int i = 0; i < LANES; i++) begin
      if (w_sel_oh[i]) begin
        w_sel   = LW'(i);
        w_instr = r_group[i*INSTR_W +: INSTR_W];
      end
    end
  end

  m_kind_classify #(.INSTR_W(INSTR_W)) u_classify (
    .i_instr (w_instr),
    .o_kind  (w_kind)
  );

  assign w_valid = (r_state == S_DRAIN);

`ifdef DECODER_KIND_TRAP_EN
  assign w_trap = w_valid && (w_kind == K_INVALID);
`else
  assign w_trap = 1'b0;
`endif

  assign w_last     = w_valid && (((r_mask & ~w_sel_oh) == '0) || w_trap);
  assign w_out_xfer = w_valid && bus.out_ready;

  // A new group may only enter while the final lane of the current one leaves.
  always_comb begin
    w_in_rdy = 1'b0;
    if (reset_n && !bus.flush) begin
      if (r_state == S_IDLE) w_in_rdy = 1'b1;
      else                   w_in_rdy = w_out_xfer && w_last;
    end
  end

  assign w_in_xfer = bus.in_valid && w_in_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_group_nxt = r_group;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        S_DRAIN: begin
          if (w_out_xfer) begin
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_mask_nxt  = '0;
            end else begin
              w_mask_nxt  = r_mask & ~w_sel_oh;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // An empty-mask group is accepted and simply dropped.
      if (w_in_xfer && (bus.in_lane_mask != '0)) begin
        w_state_nxt = S_DRAIN;
        w_mask_nxt  = bus.in_lane_mask;
        w_group_nxt = bus.in_group;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_group <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_group <= w_group_nxt;
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = w_instr;
  assign bus.out_kind  = w_kind;
  assign bus.out_lane  = w_sel;
  assign bus.out_last  = w_last;
  assign bus.out_trap  = w_trap;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_decoder_kind_seq.sv
// Directed bench for decoder_kind_seq: ordering, masking, stalls, back-to-back, trap, flush, reset.
module tb_decoder_kind_seq;
  import p_instruction::*;

  logic   clk;
  logic   reset_n;
  e_state dbg_state;
  int     n_tests;
  int     n_fail;

  decoder_kind_seq_if #(.LANES(4), .INSTR_W(32)) bus ();

  decoder_kind_seq #(.LANES(4), .INSTR_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed view: {valid, lane[1:0], kind[2:0], last, trap, instr[31:0]}
  function automatic logic [39:0] obs();
    return {bus.out_valid, bus.out_lane, bus.out_kind, bus.out_last, bus.out_trap, bus.out_instr};
  endfunction

  task automatic offer(input logic [127:0] grp, input logic [3:0] mask);
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.in_group     = grp;
    bus.in_lane_mask = mask;
    #1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_trap} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b exp 0000",
               {bus.in_ready, bus.out_valid, bus.out_last, bus.out_trap});
    end
    n_tests++;
    if (dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d exp %0d", dbg_state, S_IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    e_kind       k [4];
    logic [39:0] e;
    w = '{32'h0000_0011, 32'h1000_0022, 32'h5000_0033, 32'hC000_0044};
    k = '{K_RRR, K_MEMORY, K_RRI, K_CUSTOM};
    bus.out_ready = 1'b1;
    offer({w[3], w[2], w[1], w[0]}, 4'b1111);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_in_ready: got %b exp 1", bus.in_ready);
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 2'(i), k[i], (i == 3), 1'b0, w[i]};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL basic_lane%0d: got %h exp %h", i, obs(), e);
      end
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end_valid: got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_sparse();
    logic [31:0] w [4];
    logic [39:0] e;
    w = '{32'h0000_0011, 32'h1000_0022, 32'h5000_0033, 32'hC000_0044};
    bus.out_ready = 1'b1;
    offer({w[3], w[2], w[1], w[0]}, 4'b1010);
    idle_in();
    e = {1'b1, 2'd1, K_MEMORY, 1'b0, 1'b0, w[1]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL sparse_lane1: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    #1;
    e = {1'b1, 2'd3, K_CUSTOM, 1'b1, 1'b0, w[3]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL sparse_lane3: got %h exp %h", obs(), e);
    end
    // Empty mask: accepted and dropped, nothing emitted.
    offer({w[3], w[2], w[1], w[0]}, 4'b0000);
    idle_in();
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL empty_mask: got valid,ready=%b exp 01", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL empty_mask_hold: got valid,ready=%b exp 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_stall();
    logic [31:0] w [4];
    e_kind       k [4];
    logic [39:0] e;
    w = '{32'h2000_0A01, 32'h4000_0A02, 32'hD000_0A03, 32'h0000_0A04};
    k = '{K_MODEL, K_RRI, K_CUSTOM, K_RRR};
    bus.out_ready = 1'b1;
    offer({w[3], w[2], w[1], w[0]}, 4'b1111);
    idle_in();
    e = {1'b1, 2'd0, k[0], 1'b0, 1'b0, w[0]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL stall_lane0: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      e = {1'b1, 2'd1, k[1], 1'b0, 1'b0, w[1]};
      n_tests++;
      if ({obs(), bus.in_ready} !== {e, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h,%b exp %h,0", c, obs(), bus.in_ready, e);
      end
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      e = {1'b1, 2'(i), k[i], (i == 3), 1'b0, w[i]};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stall_resume_lane%0d: got %h exp %h", i, obs(), e);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    e_kind       ka [4];
    e_kind       kb [4];
    logic [39:0] e;
    a  = '{32'h0000_0011, 32'h1000_0022, 32'h5000_0033, 32'hC000_0044};
    ka = '{K_RRR, K_MEMORY, K_RRI, K_CUSTOM};
    b  = '{32'h2000_0101, 32'h4000_0202, 32'hD000_0303, 32'h0000_0404};
    kb = '{K_MODEL, K_RRI, K_CUSTOM, K_RRR};
    bus.out_ready = 1'b1;
    offer({a[3], a[2], a[1], a[0]}, 4'b1111);
    idle_in();
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 2'(i), ka[i], (i == 3), 1'b0, a[i]};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL b2b_a_lane%0d: got %h exp %h", i, obs(), e);
      end
      if (i == 3) begin
        bus.in_valid     = 1'b1;
        bus.in_group     = {b[3], b[2], b[1], b[0]};
        bus.in_lane_mask = 4'b1111;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready_on_last: got %b exp 1", bus.in_ready);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      e = {1'b1, 2'(i), kb[i], (i == 3), 1'b0, b[i]};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL b2b_b_lane%0d: got %h exp %h", i, obs(), e);
      end
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_valid: got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_trap();
    logic [31:0] w [4];
    e_kind       k [4];
    logic [39:0] e;
    int          n_emit;
    logic        trap1;
    w = '{32'h0000_0A0A, 32'h3000_0B0B, 32'h1000_0C0C, 32'h5000_0D0D};
    k = '{K_RRR, K_INVALID, K_MEMORY, K_RRI};
`ifdef DECODER_KIND_TRAP_EN
    n_emit = 2;
    trap1  = 1'b1;
`else
    n_emit = 4;
    trap1  = 1'b0;
`endif
    bus.out_ready = 1'b1;
    offer({w[3], w[2], w[1], w[0]}, 4'b1111);
    idle_in();
    for (int i = 0; i < n_emit; i++) begin
      e = {1'b1, 2'(i), k[i], (i == n_emit - 1), (i == 1) && trap1, w[i]};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL trap_lane%0d: got %h exp %h", i, obs(), e);
      end
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_end_valid: got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [39:0] e;
    a = '{32'h0000_0011, 32'h1000_0022, 32'h5000_0033, 32'hC000_0044};
    b = '{32'h2000_0101, 32'h4000_0202, 32'hD000_0303, 32'h0000_0404};
    bus.out_ready = 1'b1;
    offer({a[3], a[2], a[1], a[0]}, 4'b1111);
    idle_in();
    e = {1'b1, 2'd0, K_RRR, 1'b0, 1'b0, a[0]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL flush_lane0: got %h exp %h", obs(), e);
    end
    // Flush competes with a simultaneous offer and an output transfer; it wins.
    @(negedge clk);
    bus.flush        = 1'b1;
    bus.in_valid     = 1'b1;
    bus.in_group     = {b[3], b[2], b[1], b[0]};
    bus.in_lane_mask = 4'b1111;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b exp 0", bus.in_ready);
    end
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, dbg_state} !== {1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL flush_after: got valid,state=%b exp 00", {bus.out_valid, dbg_state});
    end
    offer({b[3], b[2], b[1], b[0]}, 4'b1100);
    idle_in();
    e = {1'b1, 2'd2, K_CUSTOM, 1'b0, 1'b0, b[2]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL flush_next_lane2: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    #1;
    e = {1'b1, 2'd3, K_RRR, 1'b1, 1'b0, b[3]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL flush_next_lane3: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [4];
    logic [39:0] e;
    a = '{32'h0000_0011, 32'h1000_0022, 32'h5000_0033, 32'hC000_0044};
    bus.out_ready = 1'b1;
    offer({a[3], a[2], a[1], a[0]}, 4'b1111);
    idle_in();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready, bus.out_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_during: got valid,ready,last=%b exp 000",
               {bus.out_valid, bus.in_ready, bus.out_last});
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_after: got valid,ready=%b exp 01", {bus.out_valid, bus.in_ready});
    end
    offer({a[3], a[2], a[1], a[0]}, 4'b0110);
    idle_in();
    e = {1'b1, 2'd1, K_MEMORY, 1'b0, 1'b0, a[1]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL rstmid_next_lane1: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    #1;
    e = {1'b1, 2'd2, K_RRI, 1'b1, 1'b0, a[2]};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL rstmid_next_lane2: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_group     = '0;
    bus.in_lane_mask = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_basic();
    test_sparse();
    test_stall();
    test_back_to_back();
    test_trap();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
